exu_dec_queue: RTL and testbench

Registered decode stage between the IFU and the EXU dispatch. It accepts fetched instructions over a valid/ready handshake and fully decodes RV32I, plus RV32M when enabled. Decoded bundles are held in a DEPTH-entry FIFO and presented to dispatch through a second valid/ready handshake. Beyond plain decode, it adds illegal-instruction detection, flush, back-pressure and a distinct LUI decode.

---
 rtl/exu_dec_pkg.sv | 79 +++++++
 rtl/exu_dec_core.sv | 226 ++++++++++++++++++++++
 rtl/exu_dec_queue.sv | 148 ++++++++++++++
 tb/tb_exu_dec_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_dec_pkg.sv
// Shared decode definitions: group and per-group op encodings, opcode and funct constants.
package exu_dec_pkg;

    typedef enum logic [2:0] {
        GRP_ALU = 3'd0,
        GRP_AGU = 3'd1,
        GRP_BJP = 3'd2,
        GRP_MUL = 3'd3,
        GRP_SYS = 3'd4
    } exu_grp_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_NOP  = 4'd11
    } alu_op_e;

    typedef enum logic [3:0] {
        AGU_LOAD  = 4'd0,
        AGU_STORE = 4'd1
    } agu_op_e;

    typedef enum logic [3:0] {
        BJP_JAL  = 4'd0,
        BJP_JALR = 4'd1,
        BJP_BEQ  = 4'd2,
        BJP_BNE  = 4'd3,
        BJP_BLT  = 4'd4,
        BJP_BGE  = 4'd5,
        BJP_BLTU = 4'd6,
        BJP_BGEU = 4'd7
    } bjp_op_e;

    typedef enum logic [3:0] {
        MUL_MUL    = 4'd0,
        MUL_MULH   = 4'd1,
        MUL_MULHSU = 4'd2,
        MUL_MULHU  = 4'd3,
        MUL_DIV    = 4'd4,
        MUL_DIVU   = 4'd5,
        MUL_REM    = 4'd6,
        MUL_REMU   = 4'd7
    } mul_op_e;

    typedef enum logic [3:0] {
        SYS_ECALL  = 4'd0,
        SYS_EBREAK = 4'd1,
        SYS_FENCE  = 4'd2
    } sys_op_e;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [24:0] SYS_ECALL_BITS  = 25'h0000000;
    localparam logic [24:0] SYS_EBREAK_BITS = 25'h0002000;

endpackage

// File: rtl/exu_dec_core.sv
// Pure combinational RV32I(+M) decoder: raw instruction in, dispatch bundle fields out.
module exu_dec_core
    import exu_dec_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int EN_MULDIV   = 1
) (
    input  logic [31:0]            instr,
    output logic [2:0]             grp,
    output logic [3:0]             op,
    output logic [RFIDX_WIDTH-1:0] rs1idx,
    output logic [RFIDX_WIDTH-1:0] rs2idx,
    output logic [RFIDX_WIDTH-1:0] rdidx,
    output logic                   rs1en,
    output logic                   rs2en,
    output logic                   rdwen,
    output logic [XLEN-1:0]        imm,
    output logic                   op2imm,
    output logic                   op1pc,
    output logic [1:0]             lsu_size,
    output logic                   lsu_usign,
    output logic                   ilegl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_sh = XLEN'(instr[24:20]);

    exu_grp_e        d_grp;
    logic [3:0]      d_op;
    logic            use_rs1, use_rs2, use_rd;
    logic [XLEN-1:0] d_imm;
    logic            d_op2imm, d_op1pc, d_lsu, ill;

    always_comb begin
        d_grp    = GRP_ALU;
        d_op     = ALU_NOP;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        d_imm    = '0;
        d_op2imm = 1'b0;
        d_op1pc  = 1'b0;
        d_lsu    = 1'b0;
        ill      = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  d_op = ALU_ADD;
                            3'b001:  d_op = ALU_SLL;
                            3'b010:  d_op = ALU_SLT;
                            3'b011:  d_op = ALU_SLTU;
                            3'b100:  d_op = ALU_XOR;
                            3'b101:  d_op = ALU_SRL;
                            3'b110:  d_op = ALU_OR;
                            default: d_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'b000:  d_op = ALU_SUB;
                            3'b101:  d_op = ALU_SRA;
                            default: ill  = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        if (EN_MULDIV != 0) begin
                            d_grp = GRP_MUL;
                            case (funct3)
                                3'b000:  d_op = MUL_MUL;
                                3'b001:  d_op = MUL_MULH;
                                3'b010:  d_op = MUL_MULHSU;
                                3'b011:  d_op = MUL_MULHU;
                                3'b100:  d_op = MUL_DIV;
                                3'b101:  d_op = MUL_DIVU;
                                3'b110:  d_op = MUL_REM;
                                default: d_op = MUL_REMU;
                            endcase
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                d_op2imm = 1'b1;
                d_imm    = imm_i;
                case (funct3)
                    3'b000: d_op = ALU_ADD;
                    3'b010: d_op = ALU_SLT;
                    3'b011: d_op = ALU_SLTU;
                    3'b100: d_op = ALU_XOR;
                    3'b110: d_op = ALU_OR;
                    3'b111: d_op = ALU_AND;
                    3'b001: begin
                        d_op  = ALU_SLL;
                        d_imm = imm_sh;
                        ill   = (funct7 != F7_BASE);
                    end
                    default: begin
                        d_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        d_imm = imm_sh;
                        ill   = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_LUI: begin
                d_op     = ALU_LUI;
                use_rd   = 1'b1;
                d_op2imm = 1'b1;
                d_imm    = imm_u;
            end
            OPC_AUIPC: begin
                d_op     = ALU_ADD;
                use_rd   = 1'b1;
                d_op2imm = 1'b1;
                d_op1pc  = 1'b1;
                d_imm    = imm_u;
            end
            OPC_LOAD: begin
                d_grp    = GRP_AGU;
                d_op     = AGU_LOAD;
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                d_op2imm = 1'b1;
                d_lsu    = 1'b1;
                d_imm    = imm_i;
                ill      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                d_grp    = GRP_AGU;
                d_op     = AGU_STORE;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                d_op2imm = 1'b1;
                d_lsu    = 1'b1;
                d_imm    = imm_s;
                ill      = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
            end
            OPC_BRANCH: begin
                d_grp   = GRP_BJP;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_imm   = imm_b;
                case (funct3)
                    3'b000:  d_op = BJP_BEQ;
                    3'b001:  d_op = BJP_BNE;
                    3'b100:  d_op = BJP_BLT;
                    3'b101:  d_op = BJP_BGE;
                    3'b110:  d_op = BJP_BLTU;
                    3'b111:  d_op = BJP_BGEU;
                    default: ill  = 1'b1;
                endcase
            end
            OPC_JAL: begin
                d_grp  = GRP_BJP;
                d_op   = BJP_JAL;
                use_rd = 1'b1;
                d_imm  = imm_j;
            end
            OPC_JALR: begin
                d_grp   = GRP_BJP;
                d_op    = BJP_JALR;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                d_imm   = imm_i;
                ill     = (funct3 != 3'b000);
            end
            OPC_SYSTEM: begin
                d_grp = GRP_SYS;
                // Only the two fully-specified encodings are accepted; CSR forms are not handled here.
                if (instr[31:7] == SYS_ECALL_BITS)       d_op = SYS_ECALL;
                else if (instr[31:7] == SYS_EBREAK_BITS) d_op = SYS_EBREAK;
                else                                     ill  = 1'b1;
            end
            OPC_MISC_MEM: begin
                d_grp = GRP_SYS;
                d_op  = SYS_FENCE;
                ill   = (funct3 != 3'b000);
            end
            default: ill = 1'b1;
        endcase
    end

    assign ilegl     = ill;
    assign grp       = ill ? GRP_ALU : d_grp;
    assign op        = ill ? 4'(ALU_NOP) : d_op;
    assign rs1idx    = ill ? '0 : RFIDX_WIDTH'(rs1);
    assign rs2idx    = ill ? '0 : RFIDX_WIDTH'(rs2);
    assign rdidx     = ill ? '0 : RFIDX_WIDTH'(rd);
    assign rs1en     = !ill && use_rs1 && (rs1 != 5'd0);
    assign rs2en     = !ill && use_rs2 && (rs2 != 5'd0);
    assign rdwen     = !ill && use_rd && (rd != 5'd0);
    assign imm       = ill ? '0 : d_imm;
    assign op2imm    = !ill && d_op2imm;
    assign op1pc     = !ill && d_op1pc;
    assign lsu_size  = (!ill && d_lsu) ? funct3[1:0] : 2'b00;
    assign lsu_usign = !ill && d_lsu && funct3[2];

endmodule

// File: rtl/exu_dec_queue.sv
// Decode stage: decodes IFU instructions and buffers the bundles in a DEPTH-entry FIFO for dispatch.
module exu_dec_queue
    import exu_dec_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PC_SIZE     = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int DEPTH       = 2,
    parameter int EN_MULDIV   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [31:0]            i_instr,
    input  logic [PC_SIZE-1:0]     i_pc,
    input  logic                   i_prdt_taken,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [2:0]             o_grp,
    output logic [3:0]             o_op,
    output logic [RFIDX_WIDTH-1:0] o_rs1idx,
    output logic [RFIDX_WIDTH-1:0] o_rs2idx,
    output logic [RFIDX_WIDTH-1:0] o_rdidx,
    output logic                   o_rs1en,
    output logic                   o_rs2en,
    output logic                   o_rdwen,
    output logic [XLEN-1:0]        o_imm,
    output logic [PC_SIZE-1:0]     o_pc,
    output logic                   o_op2imm,
    output logic                   o_op1pc,
    output logic [1:0]             o_lsu_size,
    output logic                   o_lsu_usign,
    output logic                   o_prdt_taken,
    output logic                   o_ilegl
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]             grp;
        logic [3:0]             op;
        logic [RFIDX_WIDTH-1:0] rs1idx;
        logic [RFIDX_WIDTH-1:0] rs2idx;
        logic [RFIDX_WIDTH-1:0] rdidx;
        logic                   rs1en;
        logic                   rs2en;
        logic                   rdwen;
        logic [XLEN-1:0]        imm;
        logic [PC_SIZE-1:0]     pc;
        logic                   op2imm;
        logic                   op1pc;
        logic [1:0]             lsu_size;
        logic                   lsu_usign;
        logic                   prdt_taken;
        logic                   ilegl;
    } bundle_t;

    bundle_t dec_b;

    exu_dec_core #(
        .XLEN        (XLEN),
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .EN_MULDIV   (EN_MULDIV)
    ) u_core (
        .instr     (i_instr),
        .grp       (dec_b.grp),
        .op        (dec_b.op),
        .rs1idx    (dec_b.rs1idx),
        .rs2idx    (dec_b.rs2idx),
        .rdidx     (dec_b.rdidx),
        .rs1en     (dec_b.rs1en),
        .rs2en     (dec_b.rs2en),
        .rdwen     (dec_b.rdwen),
        .imm       (dec_b.imm),
        .op2imm    (dec_b.op2imm),
        .op1pc     (dec_b.op1pc),
        .lsu_size  (dec_b.lsu_size),
        .lsu_usign (dec_b.lsu_usign),
        .ilegl     (dec_b.ilegl)
    );

    assign dec_b.pc         = i_pc;
    assign dec_b.prdt_taken = i_prdt_taken;

    bundle_t            mem [DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic [CNT_W-1:0]   cnt;
    logic               full, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake flags derive only from registered count, so ready never depends on o_ready.
    assign full    = (cnt == CNT_W'(DEPTH));
    assign i_ready = !full;
    assign o_valid = (cnt != '0);
    assign push    = i_valid && i_ready;
    assign pop     = o_valid && o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= dec_b;
    end

    bundle_t out_b;
    assign out_b = o_valid ? mem[rptr] : '0;

    assign o_grp        = out_b.grp;
    assign o_op         = out_b.op;
    assign o_rs1idx     = out_b.rs1idx;
    assign o_rs2idx     = out_b.rs2idx;
    assign o_rdidx      = out_b.rdidx;
    assign o_rs1en      = out_b.rs1en;
    assign o_rs2en      = out_b.rs2en;
    assign o_rdwen      = out_b.rdwen;
    assign o_imm        = out_b.imm;
    assign o_pc         = out_b.pc;
    assign o_op2imm     = out_b.op2imm;
    assign o_op1pc      = out_b.op1pc;
    assign o_lsu_size   = out_b.lsu_size;
    assign o_lsu_usign  = out_b.lsu_usign;
    assign o_prdt_taken = out_b.prdt_taken;
    assign o_ilegl      = out_b.ilegl;

endmodule

// File: tb/tb_exu_dec_queue.sv
// Directed bench for exu_dec_queue: decode vectors, back-pressure ordering, flush and async reset.
module tb_exu_dec_queue;
    import exu_dec_pkg::*;

    logic        clk, rst_n, flush, i_valid, i_prdt_taken, o_ready;
    logic [31:0] i_instr, i_pc;

    logic        i_ready, o_valid, o_rs1en, o_rs2en, o_rdwen, o_op2imm, o_op1pc;
    logic        o_lsu_usign, o_prdt_taken, o_ilegl;
    logic [2:0]  o_grp;
    logic [3:0]  o_op;
    logic [4:0]  o_rs1idx, o_rs2idx, o_rdidx;
    logic [31:0] o_imm, o_pc;
    logic [1:0]  o_lsu_size;

    logic        n_i_ready, n_o_valid, n_rs1en, n_rs2en, n_rdwen, n_op2imm, n_op1pc;
    logic        n_lsu_usign, n_prdt_taken, n_ilegl;
    logic [2:0]  n_grp;
    logic [3:0]  n_op;
    logic [4:0]  n_rs1idx, n_rs2idx, n_rdidx;
    logic [31:0] n_imm, n_pc;
    logic [1:0]  n_lsu_size;

    int checks = 0;
    int errors = 0;

    exu_dec_queue #(.DEPTH(2), .EN_MULDIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
        .i_prdt_taken(i_prdt_taken), .o_valid(o_valid), .o_ready(o_ready),
        .o_grp(o_grp), .o_op(o_op), .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx),
        .o_rdidx(o_rdidx), .o_rs1en(o_rs1en), .o_rs2en(o_rs2en), .o_rdwen(o_rdwen),
        .o_imm(o_imm), .o_pc(o_pc), .o_op2imm(o_op2imm), .o_op1pc(o_op1pc),
        .o_lsu_size(o_lsu_size), .o_lsu_usign(o_lsu_usign),
        .o_prdt_taken(o_prdt_taken), .o_ilegl(o_ilegl)
    );

    exu_dec_queue #(.DEPTH(2), .EN_MULDIV(0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_valid(i_valid), .i_ready(n_i_ready), .i_instr(i_instr), .i_pc(i_pc),
        .i_prdt_taken(i_prdt_taken), .o_valid(n_o_valid), .o_ready(o_ready),
        .o_grp(n_grp), .o_op(n_op), .o_rs1idx(n_rs1idx), .o_rs2idx(n_rs2idx),
        .o_rdidx(n_rdidx), .o_rs1en(n_rs1en), .o_rs2en(n_rs2en), .o_rdwen(n_rdwen),
        .o_imm(n_imm), .o_pc(n_pc), .o_op2imm(n_op2imm), .o_op1pc(n_op1pc),
        .o_lsu_size(n_lsu_size), .o_lsu_usign(n_lsu_usign),
        .o_prdt_taken(n_prdt_taken), .o_ilegl(n_ilegl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic prdt);
        i_valid      = 1'b1;
        i_instr      = instr;
        i_pc         = pc;
        i_prdt_taken = prdt;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0;
        i_prdt_taken = 1'b0; o_ready = 1'b1;
        #12;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_i_ready", i_ready, 1);
        chk("rst_imm", o_imm, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_grp", o_grp, 0);
        rst_n = 1'b1;

        // One instruction per cycle with o_ready=1: each push is visible the cycle after.
        drive(32'hFFF10093, 32'h80000000, 1'b0);
        tick();
        chk("addi_valid", o_valid, 1);
        chk("addi_grp", o_grp, GRP_ALU);
        chk("addi_op", o_op, ALU_ADD);
        chk("addi_imm", o_imm, 32'hFFFFFFFF);
        chk("addi_rs1en", o_rs1en, 1);
        chk("addi_rs1idx", o_rs1idx, 2);
        chk("addi_rdwen", o_rdwen, 1);
        chk("addi_rdidx", o_rdidx, 1);
        chk("addi_rs2en", o_rs2en, 0);
        chk("addi_op2imm", o_op2imm, 1);
        chk("addi_pc", o_pc, 32'h80000000);
        chk("addi_ilegl", o_ilegl, 0);

        drive(32'h123452B7, 32'h80000004, 1'b0);
        tick();
        chk("lui_op", o_op, ALU_LUI);
        chk("lui_imm", o_imm, 32'h12345000);
        chk("lui_rs1en", o_rs1en, 0);
        chk("lui_op1pc", o_op1pc, 0);
        chk("lui_rdidx", o_rdidx, 5);
        chk("lui_pc", o_pc, 32'h80000004);

        drive(32'h12345297, 32'h80000008, 1'b0);
        tick();
        chk("auipc_op", o_op, ALU_ADD);
        chk("auipc_op1pc", o_op1pc, 1);
        chk("auipc_imm", o_imm, 32'h12345000);

        drive(32'hFE000EE3, 32'h8000000C, 1'b1);
        tick();
        chk("beq_grp", o_grp, GRP_BJP);
        chk("beq_op", o_op, BJP_BEQ);
        chk("beq_imm", o_imm, 32'hFFFFFFFC);
        chk("beq_en", {o_rs1en, o_rs2en, o_rdwen}, 3'b000);
        chk("beq_prdt", o_prdt_taken, 1);
        chk("beq_op2imm", o_op2imm, 0);

        drive(32'h022081B3, 32'h80000010, 1'b0);
        tick();
        chk("mul_grp", o_grp, GRP_MUL);
        chk("mul_op", o_op, MUL_MUL);
        chk("mul_ilegl", o_ilegl, 0);
        chk("mul_en", {o_rs1en, o_rs2en, o_rdwen}, 3'b111);
        chk("nm_mul_ilegl", n_ilegl, 1);
        chk("nm_mul_en", {n_rs1en, n_rs2en, n_rdwen}, 3'b000);
        chk("nm_mul_grp", n_grp, GRP_ALU);
        chk("nm_mul_op", n_op, ALU_NOP);

        drive(32'h00000000, 32'h80000014, 1'b0);
        tick();
        chk("zero_ilegl", o_ilegl, 1);
        chk("zero_op", o_op, ALU_NOP);

        drive(32'h40109093, 32'h80000018, 1'b0);
        tick();
        chk("bad_slli_ilegl", o_ilegl, 1);
        chk("bad_slli_rdwen", o_rdwen, 0);

        drive(32'h4030D093, 32'h8000001C, 1'b0);
        tick();
        chk("srai_op", o_op, ALU_SRA);
        chk("srai_imm", o_imm, 3);
        chk("srai_ilegl", o_ilegl, 0);

        drive(32'hFF812283, 32'h80000020, 1'b0);
        tick();
        chk("lw_grp", o_grp, GRP_AGU);
        chk("lw_op", o_op, AGU_LOAD);
        chk("lw_imm", o_imm, 32'hFFFFFFF8);
        chk("lw_size", o_lsu_size, 2);
        chk("lw_usign", o_lsu_usign, 0);

        drive(32'h00612623, 32'h80000024, 1'b0);
        tick();
        chk("sw_op", o_op, AGU_STORE);
        chk("sw_imm", o_imm, 12);
        chk("sw_rdwen", o_rdwen, 0);
        chk("sw_rs2", {o_rs2en, o_rs2idx}, {1'b1, 5'd6});

        drive(32'h00000073, 32'h80000028, 1'b0);
        tick();
        chk("ecall_grp", o_grp, GRP_SYS);
        chk("ecall_op", o_op, SYS_ECALL);
        chk("ecall_ilegl", o_ilegl, 0);

        i_valid = 1'b0;
        tick();
        chk("drain_valid", o_valid, 0);
        chk("drain_imm", o_imm, 0);

        // Back-pressure: three offers with dispatch stalled.
        o_ready = 1'b0;
        drive(32'hFFF10093, 32'h00000100, 1'b0);
        tick();
        chk("bp1_ready", i_ready, 1);
        drive(32'h123452B7, 32'h00000104, 1'b0);
        tick();
        chk("bp2_ready", i_ready, 0);
        drive(32'h12345297, 32'h00000108, 1'b0);
        tick();
        chk("bp3_ready", i_ready, 0);
        chk("bp3_pc", o_pc, 32'h100);
        o_ready = 1'b1;
        tick();
        chk("bp4_pc", o_pc, 32'h104);
        chk("bp4_ready", i_ready, 1);
        tick();
        chk("bp5_pc", o_pc, 32'h108);
        chk("bp5_op1pc", o_op1pc, 1);
        i_valid = 1'b0;
        tick();
        chk("bp6_valid", o_valid, 0);

        // Flush with a simultaneous push.
        o_ready = 1'b0;
        drive(32'hFFF10093, 32'h00000200, 1'b0);
        tick();
        drive(32'hFFF10093, 32'h00000204, 1'b0);
        tick();
        chk("fl_pre_valid", o_valid, 1);
        drive(32'h123452B7, 32'h00000208, 1'b0);
        flush = 1'b1;
        o_ready = 1'b1;
        tick();
        flush = 1'b0;
        i_valid = 1'b0;
        chk("fl_valid", o_valid, 0);
        chk("fl_ready", i_ready, 1);
        tick();
        chk("fl_post_valid", o_valid, 0);

        // Asynchronous reset mid-stream.
        o_ready = 1'b0;
        drive(32'hFFF10093, 32'h00000300, 1'b1);
        tick();
        tick();
        i_valid = 1'b0;
        chk("rs_pre_ready", i_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rs_valid", o_valid, 0);
        chk("rs_ready", i_ready, 1);
        chk("rs_pc", o_pc, 0);
        chk("rs_imm", o_imm, 0);
        chk("rs_prdt", o_prdt_taken, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rs_post_valid", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
